// File: rtl/ara_pkg.sv
// Shared vector load/store types plus the burst-split arithmetic.
// The global load/store unit reuses this arithmetic.
package ara_pkg;

  localparam int unsigned VLenClusterWidth = 16;
  typedef logic [VLenClusterWidth-1:0] vlen_cluster_t;

  typedef enum logic [1:0] {
    EW8  = 2'd0,
    EW16 = 2'd1,
    EW32 = 2'd2,
    EW64 = 2'd3
  } vew_e;

  typedef enum logic {
    LDST_IDLE  = 1'b0,
    LDST_ISSUE = 1'b1
  } ldst_state_e;

  localparam int unsigned AxiPageBytes = 4096;

  // Beats in the next burst. The page term uses the beat-aligned address.
  // Only the low address bits matter, because a page is at most 2^31 bytes.
  function automatic logic [8:0] burst_beats(
    input logic [31:0] addr_lo,
    input logic [31:0] beats_rem,
    input logic [31:0] max_beats,
    input logic [31:0] page_bytes,
    input logic [31:0] beat_bytes
  );
    logic [31:0] page_off;
    logic [31:0] page_beats;
    logic [31:0] beats;
    page_off   = addr_lo & (page_bytes - 32'd1) & ~(beat_bytes - 32'd1);
    page_beats = (page_bytes - page_off) / beat_bytes;
    beats      = beats_rem;
    if (max_beats < beats) beats = max_beats;
    if (page_beats < beats) beats = page_beats;
    return 9'(beats);
  endfunction

endpackage

// File: rtl/ldst_burst_sequencer.sv
// Splits one vector memory command into page- and length-legal AXI AR/AW bursts,
// holding per-command vl/element width on sideband outputs for the align stage.
module ldst_burst_sequencer
  import ara_pkg::*;
#(
  parameter int unsigned AxiDataWidth  = 512,
  parameter int unsigned AxiAddrWidth  = 64,
  parameter int unsigned MaxBurstBeats = 256,
  parameter int unsigned PageBytes     = AxiPageBytes
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [AxiAddrWidth-1:0] cmd_addr_i,
  input  vlen_cluster_t           cmd_vl_i,
  input  vew_e                    cmd_vew_i,
  input  logic                    cmd_is_load_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [AxiAddrWidth-1:0] ax_addr_o,
  output logic [7:0]              ax_len_o,
  output logic [2:0]              ax_size_o,
  output vlen_cluster_t           vl_ldst_rd_o,
  output vlen_cluster_t           vl_ldst_wr_o,
  output vew_e                    vew_ar_o,
  output vew_e                    vew_aw_o,
  output logic                    busy_o
);

  localparam int unsigned BeatBytes  = AxiDataWidth / 8;
  localparam int unsigned BeatShift  = $clog2(BeatBytes);
  localparam int unsigned BytesWidth = $bits(vlen_cluster_t) + 3;
  localparam int unsigned RemWidth   = BytesWidth + 1;

  ldst_state_e             state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    is_load_q, is_load_d;
  logic [AxiAddrWidth-1:0] cur_addr_q, cur_addr_d;
  logic [RemWidth-1:0]     beats_rem_q, beats_rem_d;
  vlen_cluster_t           vl_rd_q, vl_rd_d, vl_wr_q, vl_wr_d;
  vew_e                    vew_ar_q, vew_ar_d, vew_aw_q, vew_aw_d;

  logic [BytesWidth-1:0]   cmd_bytes;
  logic [RemWidth-1:0]     cmd_span;
  logic [AxiAddrWidth-1:0] aligned_addr;
  logic [8:0]              beats;
  logic                    busy;
  logic                    ax_hs;

  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    cur_addr_d  = cur_addr_q;
    beats_rem_d = beats_rem_q;
    vl_rd_d     = vl_rd_q;
    vl_wr_d     = vl_wr_q;
    vew_ar_d    = vew_ar_q;
    vew_aw_d    = vew_aw_q;

    busy      = (state_q == LDST_ISSUE);
    cmd_bytes = BytesWidth'(cmd_vl_i) << cmd_vew_i;
    // Leading offset plus payload, rounded up to whole beats.
    cmd_span  = RemWidth'(cmd_addr_i[BeatShift-1:0]) + RemWidth'(cmd_bytes)
              + RemWidth'(BeatBytes - 1);

    beats        = burst_beats(cur_addr_q[31:0], 32'(beats_rem_q), MaxBurstBeats,
                               PageBytes, BeatBytes);
    aligned_addr = cur_addr_q & ~AxiAddrWidth'(BeatBytes - 1);
    ax_hs        = busy && (is_load_q ? ar_ready_i : aw_ready_i);

    case (state_q)
      LDST_IDLE: begin
        // A zero-length command is consumed without touching the sideband.
        if (cmd_valid_i && cmd_ready_q && (cmd_vl_i != '0)) begin
          state_d     = LDST_ISSUE;
          is_load_d   = cmd_is_load_i;
          cur_addr_d  = cmd_addr_i;
          beats_rem_d = cmd_span >> BeatShift;
          if (cmd_is_load_i) begin
            vl_rd_d  = cmd_vl_i;
            vew_ar_d = cmd_vew_i;
          end else begin
            vl_wr_d  = cmd_vl_i;
            vew_aw_d = cmd_vew_i;
          end
        end
      end
      LDST_ISSUE: begin
        if (ax_hs) begin
          beats_rem_d = beats_rem_q - RemWidth'(beats);
          cur_addr_d  = aligned_addr + (AxiAddrWidth'(beats) << BeatShift);
          if (beats_rem_q == RemWidth'(beats)) state_d = LDST_IDLE;
        end
      end
      default: state_d = LDST_IDLE;
    endcase

    cmd_ready_d = (state_d == LDST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= LDST_IDLE;
      cmd_ready_q <= 1'b0;
      is_load_q   <= 1'b0;
      cur_addr_q  <= '0;
      beats_rem_q <= '0;
      vl_rd_q     <= '0;
      vl_wr_q     <= '0;
      vew_ar_q    <= EW8;
      vew_aw_q    <= EW8;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      is_load_q   <= is_load_d;
      cur_addr_q  <= cur_addr_d;
      beats_rem_q <= beats_rem_d;
      vl_rd_q     <= vl_rd_d;
      vl_wr_q     <= vl_wr_d;
      vew_ar_q    <= vew_ar_d;
      vew_aw_q    <= vew_aw_d;
    end
  end

  // Payload is forced to zero outside ISSUE so idle outputs are quiet.
  assign cmd_ready_o  = cmd_ready_q;
  assign ar_valid_o   = busy && is_load_q;
  assign aw_valid_o   = busy && !is_load_q;
  assign ax_addr_o    = busy ? cur_addr_q : '0;
  assign ax_len_o     = busy ? 8'(beats - 9'd1) : 8'd0;
  assign ax_size_o    = busy ? 3'(BeatShift) : 3'd0;
  assign vl_ldst_rd_o = vl_rd_q;
  assign vl_ldst_wr_o = vl_wr_q;
  assign vew_ar_o     = vew_ar_q;
  assign vew_aw_o     = vew_aw_q;
  assign busy_o       = busy;

endmodule

// File: doc/ldst_burst_sequencer.md
Name: ldst_burst_sequencer

Overview:
- Sits between the cluster load/store front-end and the align stage.
- Takes one vector memory command (base address, vl, element width, load/store) and splits it into AXI AR or AW bursts that respect the 4 KiB page limit and the maximum burst length.
- Holds the per-command vl and element width stable on its sideband outputs while the command's bursts are issued, so downstream alignment tracking sees consistent values.
- One command is in flight at a time; the next command is accepted once the last burst of the current one has been handed off.

Parameters:
- AxiDataWidth, 512, AXI data width in bits; B = AxiDataWidth/8 bytes per beat; power of two, at least 64.
- AxiAddrWidth, 64, AXI address width.
- MaxBurstBeats, 256, maximum beats per burst; range 1..256.
- PageBytes, 4096, AXI burst boundary in bytes; power of two, at least B.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_addr_i  in  AxiAddrWidth  byte base address; may be unaligned.
- cmd_vl_i  in  vlen_cluster_t  number of elements.
- cmd_vew_i  in  vew_e  element width.
- cmd_is_load_i  in  1  1 = issue on AR, 0 = issue on AW.
- ar_valid_o  out  1  AR valid.
- ar_ready_i  in  1  AR ready.
- aw_valid_o  out  1  AW valid.
- aw_ready_i  in  1  AW ready.
- ax_addr_o  out  AxiAddrWidth  burst address, shared by AR and AW.
- ax_len_o  out  8  burst length = beats-1.
- ax_size_o  out  3  log2(B).
- vl_ldst_rd_o  out  vlen_cluster_t  vl of the current load command.
- vl_ldst_wr_o  out  vlen_cluster_t  vl of the current store command.
- vew_ar_o  out  vew_e  element width of the current load.
- vew_aw_o  out  vew_e  element width of the current store.
- busy_o  out  1  a command is being issued.

Behaviour:
- Reset: all outputs 0 and state IDLE.
  - vl_ldst_rd_o, vl_ldst_wr_o, vew_ar_o and vew_aw_o keep their last values after a command completes, until the next command of the same type is accepted.
- FSM has two states, IDLE and ISSUE.
- IDLE:
  - cmd_ready_o = 1.
  - On handshake, latch the command and compute:
    - off = addr[log2(B)-1:0];
    - bytes = vl << vew, computed at width vlen_cluster_t plus 3 bits;
    - beats_rem = ceil((off + bytes)/B);
    - cur_addr = cmd_addr_i (unaligned, first burst only).
  - Update the matching vl_ldst_*_o / vew_*_o outputs in the same cycle as the handshake.
  - If vl = 0: stay in IDLE, issue no burst, and do not update the sideband outputs.
  - Otherwise go to ISSUE on the next cycle.
- ISSUE:
  - Drive ar_valid_o (load) or aw_valid_o (store); never both.
  - Burst size: beats = min(beats_rem, MaxBurstBeats, (PageBytes - cur_addr[log2(PageBytes)-1:0]) >> log2(B)), where the page term uses the beat-aligned address.
  - ax_len_o = beats-1; ax_size_o = log2(B).
  - Valid and payload are stable until the handshake; valid never drops without a handshake.
  - On handshake:
    - beats_rem -= beats;
    - cur_addr = aligned(cur_addr) + beats*B, so every following burst is beat-aligned.
    - If beats_rem becomes 0, return to IDLE.
  - At most one burst per cycle, so throughput is 1 burst/cycle when ready stays high.
- cmd_ready_o = 0 throughout ISSUE. It is a registered state decode; there is no same-cycle back-to-back acceptance, so there is 1 idle cycle between commands.
- busy_o = (state == ISSUE).
- Boundary conditions:
  - A burst ending exactly at a page edge is legal.
  - A command straddling a page is split at the edge.
  - Address wrap at 2^AxiAddrWidth is undefined and is not checked.
- Reset mid-ISSUE: the FSM returns to IDLE and any pending valid drops immediately. The resulting downstream inconsistency is the system's responsibility.
- Latency: the first ax_valid_o is asserted the cycle after cmd handshake.

Decomposition:
- Shared package ara_pkg provides:
  - vlen_cluster_t and vew_e (already exist);
  - new constant AxiPageBytes = 4096;
  - function burst_beats(addr, beats_rem, max) so the global load/store unit shares the same split arithmetic.
- Single module; no sub-module needed.

Test Plan:
- Aligned load: addr 0x1000, vl 16, vew EW64, B=64, ready always 1 -> one AR, addr 0x1000, len 1; vl_ldst_rd_o = 16, vew_ar_o = EW64.
- Unaligned load: addr 0x1008, vl 16, EW64 -> beats 3; one AR, addr 0x1008, len 2.
- Page crossing store: addr 0x1FC0, vl 32, EW64 (256 B) -> AW 0x1FC0 len 0, then AW 0x2000 len 2; aw_valid only, ar_valid 0.
- Max burst: addr 0, vl 4096, EW32 (16 KiB, MaxBurstBeats 256, page 4 KiB) -> 4 ARs of len 63 at 0x0, 0x1000, 0x2000, 0x3000.
- Backpressure: ar_ready low for 5 cycles -> ar_valid, addr and len stable; cmd_ready_o 0 throughout.
- vl = 0 -> accepted in 1 cycle, no AR/AW, busy_o stays 0.
- Reset asserted during ISSUE -> ar_valid_o 0 immediately; cmd_ready_o 1 after reset release.
